// File: rtl/cdc_hs_arb.sv
// cdc_hs_arb: round-robin arbiter that funnels N_REQ requesters onto one 4-phase
//   req/ack handshake towards an asynchronous far domain, with per-phase timeout.
// Latency: grant is combinational in an IDLE cycle; xfer_req/xfer_data registered on the grant edge.
// Backpressure: one transfer outstanding; no req_ready while busy or while the synchronized ack is high.
// Ports:
//   clk, rst_n                - clock, synchronous active-low reset
//   req_valid/req_data        - per-requester level request and payload (slot i at [i*DW +: DW])
//   req_ready                 - one-hot grant pulse; the granted payload is consumed that cycle
//   xfer_req/xfer_data        - registered 4-phase request and payload to the far domain
//   xfer_ack_async            - far-domain acknowledge, resynchronized internally
//   grant_id, busy, timeout_err - owner of current transfer, non-IDLE flag, phase-timeout pulse
module cdc_hs_arb #(
  parameter int N_REQ = 4,
  parameter int DW    = 8,
  parameter int TMO   = 255,
  localparam int GW   = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req_valid,
  input  logic [N_REQ*DW-1:0]   req_data,
  output logic [N_REQ-1:0]      req_ready,
  output logic                  xfer_req,
  output logic [DW-1:0]         xfer_data,
  input  logic                  xfer_ack_async,
  output logic [GW-1:0]         grant_id,
  output logic                  busy,
  output logic                  timeout_err
);

  localparam int CW = $clog2(TMO + 1);

  typedef enum logic [1:0] {IDLE, REQ_HI, REQ_LO} state_t;

  state_t          state_q, state_d;
  logic            ack_meta_q, ack_s_q;
  logic            xfer_req_q, xfer_req_d;
  logic [DW-1:0]   xfer_data_q, xfer_data_d;
  logic [GW-1:0]   grant_id_q, grant_id_d;
  logic [GW-1:0]   last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d, cnt_nxt;
  logic            tmo_q, tmo_d;
  logic            cnt_hit;
  logic            found;
  logic [GW-1:0]   win;
  int              idx;

  // Round-robin search starting just after the previous winner.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(last_q) + k) % N_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = GW'(idx);
      end
    end
  end

  // Saturating phase counter; "hit" means this cycle would bring it to TMO.
  assign cnt_nxt = (cnt_q == CW'(TMO)) ? cnt_q : cnt_q + 1'b1;
  assign cnt_hit = (cnt_nxt == CW'(TMO));

  always_comb begin
    state_d     = state_q;
    xfer_req_d  = xfer_req_q;
    xfer_data_d = xfer_data_q;
    grant_id_d  = grant_id_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    tmo_d       = 1'b0;
    req_ready   = '0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        // A high synchronized ack means the far side has not returned to zero yet.
        if (rst_n && !ack_s_q && found) begin
          req_ready[win] = 1'b1;
          xfer_data_d    = req_data[int'(win)*DW +: DW];
          grant_id_d     = win;
          last_d         = win;
          xfer_req_d     = 1'b1;
          state_d        = REQ_HI;
        end
      end
      REQ_HI: begin
        // Ack edge takes precedence over a coincident timeout.
        if (ack_s_q || cnt_hit) begin
          xfer_req_d = 1'b0;
          state_d    = REQ_LO;
          cnt_d      = '0;
          tmo_d      = !ack_s_q;
        end else begin
          cnt_d = cnt_nxt;
        end
      end
      REQ_LO: begin
        if (!ack_s_q || cnt_hit) begin
          state_d = IDLE;
          cnt_d   = '0;
          tmo_d   = ack_s_q;
        end else begin
          cnt_d = cnt_nxt;
        end
      end
      default: begin
        state_d    = IDLE;
        xfer_req_d = 1'b0;
        cnt_d      = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ack_meta_q  <= 1'b0;
      ack_s_q     <= 1'b0;
      xfer_req_q  <= 1'b0;
      xfer_data_q <= '0;
      grant_id_q  <= '0;
      last_q      <= GW'(N_REQ - 1);
      cnt_q       <= '0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      ack_meta_q  <= xfer_ack_async;
      ack_s_q     <= ack_meta_q;
      xfer_req_q  <= xfer_req_d;
      xfer_data_q <= xfer_data_d;
      grant_id_q  <= grant_id_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
    end
  end

  assign xfer_req    = xfer_req_q;
  assign xfer_data   = xfer_data_q;
  assign grant_id    = grant_id_q;
  assign busy        = rst_n && (state_q != IDLE);
  assign timeout_err = tmo_q;

endmodule

// File: tb/tb_cdc_hs_arb.sv
module tb_cdc_hs_arb;
  localparam int N   = 4;
  localparam int DW  = 8;
  localparam int TMO = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            xfer_req;
  logic [DW-1:0]   xfer_data;
  logic            ack;
  logic [1:0]      grant_id;
  logic            busy;
  logic            timeout_err;

  int errors = 0;
  int checks = 0;
  int last_m;
  int cur_w;
  logic [DW-1:0] cur_d;
  int order [5] = '{0, 1, 2, 3, 0};

  cdc_hs_arb #(.N_REQ(N), .DW(DW), .TMO(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .xfer_req(xfer_req), .xfer_data(xfer_data),
    .xfer_ack_async(ack), .grant_id(grant_id), .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round robin: first set requester after the previous winner, wrapping.
  function automatic int rr(input int last, input logic [N-1:0] v);
    for (int k = 1; k <= N; k++) begin
      if (v[(last + k) % N]) return (last + k) % N;
    end
    return -1;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0; ack = 1'b0; req_valid = '0;
    tick();
    rst_n = 1'b1;
    last_m = N - 1;
  endtask

  task automatic grant(input logic [N-1:0] v, input logic [N*DW-1:0] dat);
    int w;
    req_valid = v; req_data = dat;
    #1;
    w = rr(last_m, v);
    chk("grant_ready", 32'(req_ready), 32'(1 << w));
    cur_w = w; cur_d = dat[w*DW +: DW]; last_m = w;
    tick();
    chk("grant_xfer_req", 32'(xfer_req), 32'(1));
    chk("grant_busy", 32'(busy), 32'(1));
    chk("grant_data", 32'(xfer_data), 32'(cur_d));
    chk("grant_id", 32'(grant_id), 32'(cur_w));
    chk("grant_ready_off", 32'(req_ready), 32'(0));
    chk("grant_tmo", 32'(timeout_err), 32'(0));
    req_valid = N'($urandom); req_data = $urandom;
  endtask

  // Far side raises ack after seeing xfer_req for dhi cycles (0 = never).
  task automatic hi_phase(input int dhi);
    int len; bit tmo;
    tmo = !(dhi > 0 && dhi + 3 <= TMO);
    len = tmo ? TMO : dhi + 3;
    for (int j = 1; j <= len; j++) begin
      tick();
      chk("hi_xfer_req", 32'(xfer_req), 32'(j < len));
      chk("hi_tmo", 32'(timeout_err), 32'(tmo && j == len));
      chk("hi_busy", 32'(busy), 32'(1));
      chk("hi_data_hold", 32'(xfer_data), 32'(cur_d));
      chk("hi_id_hold", 32'(grant_id), 32'(cur_w));
      chk("hi_ready_off", 32'(req_ready), 32'(0));
      if (j == dhi) ack = 1'b1;
      req_data = $urandom; req_valid = N'($urandom);
    end
  endtask

  // Far side drops ack dlo cycles after xfer_req fell (0 = never).
  task automatic lo_phase(input int dlo);
    int len; bit tmo;
    if (!ack) begin
      tmo = 1'b0; len = 1;
    end else begin
      tmo = !(dlo > 0 && dlo + 3 <= TMO);
      len = tmo ? TMO : dlo + 3;
    end
    for (int m = 1; m <= len; m++) begin
      tick();
      chk("lo_xfer_req", 32'(xfer_req), 32'(0));
      chk("lo_busy", 32'(busy), 32'(m < len));
      chk("lo_tmo", 32'(timeout_err), 32'(tmo && m == len));
      chk("lo_data_hold", 32'(xfer_data), 32'(cur_d));
      chk("lo_id_hold", 32'(grant_id), 32'(cur_w));
      if (m < len) chk("lo_ready_off", 32'(req_ready), 32'(0));
      if (m == dlo) ack = 1'b0;
      if (m < len) begin
        req_data = $urandom; req_valid = N'($urandom);
      end
    end
  endtask

  initial begin
    // Reset state, with requests present during reset.
    rst_n = 1'b0; ack = 1'b0; req_valid = '1; req_data = $urandom;
    tick(); tick();
    chk("rst_ready", 32'(req_ready), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_xfer_req", 32'(xfer_req), 32'(0));
    chk("rst_xfer_data", 32'(xfer_data), 32'(0));
    chk("rst_grant_id", 32'(grant_id), 32'(0));
    chk("rst_tmo", 32'(timeout_err), 32'(0));
    rst_n = 1'b1; req_valid = '0; last_m = N - 1;

    // Single transfer from requester 2 with payload A5.
    grant(4'b0100, 32'h00A5_0000);
    chk("single_data_a5", 32'(xfer_data), 32'h A5);
    chk("single_id_2", 32'(grant_id), 32'd2);
    hi_phase(1);
    lo_phase(1);

    // Round robin with all requesters held after reset.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      grant(4'b1111, $urandom);
      chk("rr_order", 32'(grant_id), 32'(order[i]));
      hi_phase(1);
      lo_phase(1);
    end

    // No ack at all: REQ_HI times out, then a one-cycle REQ_LO.
    grant(N'($urandom_range(1, 15)), $urandom);
    hi_phase(0);
    lo_phase(1);

    // Ack arrives exactly when the counter would reach TMO: ack wins.
    grant(N'($urandom_range(1, 15)), $urandom);
    hi_phase(13);
    lo_phase(1);

    // Ack stuck high in REQ_LO: timeout, then IDLE blocks grants until ack drops.
    grant(N'($urandom_range(1, 15)), $urandom);
    hi_phase(2);
    lo_phase(0);
    req_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("blk_ready", 32'(req_ready), 32'(0));
      chk("blk_busy", 32'(busy), 32'(0));
      chk("blk_tmo_once", 32'(timeout_err), 32'(0));
    end
    ack = 1'b0;
    tick();
    chk("blk_sync_ready", 32'(req_ready), 32'(0));
    tick();
    grant(4'b1111, $urandom);
    hi_phase(1);
    lo_phase(1);

    // Ack high after reset: no grant until it is released and synchronized.
    do_reset();
    ack = 1'b1;
    tick(); tick(); tick();
    req_valid = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stuck_ready", 32'(req_ready), 32'(0));
      chk("stuck_busy", 32'(busy), 32'(0));
    end
    ack = 1'b0;
    tick();
    chk("stuck_sync_ready", 32'(req_ready), 32'(0));
    tick();
    grant(4'b0001, $urandom);
    hi_phase(1);
    lo_phase(1);

    // Reset pulse while in REQ_HI aborts; requester 0 regains priority.
    grant(4'b1110, $urandom);
    tick(); tick();
    rst_n = 1'b0;
    tick();
    chk("abort_xfer_req", 32'(xfer_req), 32'(0));
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_tmo", 32'(timeout_err), 32'(0));
    chk("abort_ready", 32'(req_ready), 32'(0));
    chk("abort_data", 32'(xfer_data), 32'(0));
    rst_n = 1'b1; last_m = N - 1;
    grant(4'b1111, $urandom);
    chk("abort_next_id", 32'(grant_id), 32'd0);
    hi_phase(1);
    lo_phase(1);

    // Random traffic and far-side latencies.
    for (int t = 0; t < 25; t++) begin
      grant(N'($urandom_range(1, 15)), $urandom);
      hi_phase($urandom_range(1, 10));
      lo_phase($urandom_range(1, 10));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
